// File: rtl/hs_pkg.sv
// Shared types for the handshake byte FIFO.
// Occupancy decode helper used by the FIFO controller.
package hs_pkg;

   parameter int HS_DATA_W = 8;

   typedef logic [HS_DATA_W-1:0] hs_data_t;

   typedef enum {HS_EMPTY, HS_PARTIAL, HS_FULL} hs_occ_e;

   function automatic hs_occ_e hs_occ(
      input int unsigned cnt,
      input int unsigned depth
   );
      if (cnt == 0) return HS_EMPTY;
      if (cnt >= depth) return HS_FULL;
      return HS_PARTIAL;
   endfunction

endpackage

// File: rtl/hs_fifo_mem.sv
// DEPTH x DATA_W register array: one write port, one async read port.
// Contents are not reset; validity is tracked by the controller.
module hs_fifo_mem
   import hs_pkg::*;
#(
   parameter int DATA_W = HS_DATA_W,
   parameter int DEPTH  = 4,
   parameter int AW     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              i_we,
   input  logic [AW-1:0]     i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [AW-1:0]     i_raddr,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/hs_byte_fifo.sv
// First-word-fall-through byte FIFO with registered in_ready.
// Optional SVA checkers: define HS_BYTE_FIFO_ASSERT_EN.
module hs_byte_fifo
   import hs_pkg::*;
#(
   parameter int DATA_W = HS_DATA_W,
   parameter int DEPTH  = 4,
   parameter int PW     = $clog2(DEPTH),
   parameter int CW     = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CW-1:0]     count
);

   localparam logic [CW-1:0] ONE   = CW'(1);
   localparam logic [CW-1:0] FULLC = CW'(DEPTH);

   logic [PW-1:0]     r_wr_ptr;
   logic [PW-1:0]     r_rd_ptr;
   logic [CW-1:0]     r_count;
   logic              r_in_ready;
   logic [CW-1:0]     w_cnt_nxt;
   logic              w_push;
   logic              w_pop;
   logic              w_out_valid;
   logic [DATA_W-1:0] w_rd_data;
   hs_occ_e           w_occ;

   assign w_occ       = hs_occ(32'(r_count), DEPTH);
   assign w_out_valid = (w_occ != HS_EMPTY);
   assign w_push      = in_valid & r_in_ready;
   assign w_pop       = w_out_valid & out_ready;

   always_comb begin
      w_cnt_nxt = r_count;
      unique case ({w_push, w_pop})
         2'b10:   w_cnt_nxt = r_count + ONE;
         2'b01:   w_cnt_nxt = r_count - ONE;
         default: w_cnt_nxt = r_count;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_in_ready <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         r_count    <= w_cnt_nxt;
         r_in_ready <= (w_cnt_nxt != FULLC);
      end
   end

   hs_fifo_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AW     (PW)
   ) u_mem (
      .clk     (clk),
      .i_we    (w_push),
      .i_waddr (r_wr_ptr),
      .i_wdata (in_data),
      .i_raddr (r_rd_ptr),
      .o_rdata (w_rd_data)
   );

   // Zero the head when empty so stale storage never leaks out.
   assign out_data  = w_out_valid ? w_rd_data : '0;
   assign out_valid = w_out_valid;
   assign in_ready  = r_in_ready;
   assign count     = r_count;

`ifdef HS_BYTE_FIFO_ASSERT_EN
   a_stall: assert property (
      @(posedge clk) disable iff (rst)
      out_valid && !out_ready |=> out_valid && $stable(out_data)
   ) else $error("hs_byte_fifo: stall stability violated");

   a_cnt: assert property (
      @(posedge clk) disable iff (rst)
      r_count <= FULLC
   ) else $error("hs_byte_fifo: count above DEPTH");

   a_rdy: assert property (
      @(posedge clk) disable iff (rst)
      !(r_in_ready && w_occ == HS_FULL)
   ) else $error("hs_byte_fifo: in_ready while full");
`else
   // Default build carries no checkers.
`endif

endmodule

// File: tb/tb_hs_byte_fifo.sv
// Directed bench for hs_byte_fifo: reset, stall, fill, stream,
// mid-stream reset and a random-backpressure scoreboard run.
module tb_hs_byte_fifo;
   import hs_pkg::*;

   logic     clk = 1'b0;
   logic     rst;
   logic     in_valid;
   logic     in_ready;
   hs_data_t in_data;
   logic     out_valid;
   logic     out_ready;
   hs_data_t out_data;
   logic [2:0] count;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   hs_byte_fifo #(.DATA_W(8), .DEPTH(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .count     (count)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(
      input string       tag,
      input logic [31:0] obs,
      input logic [31:0] exp
   );
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   hs_data_t q[$];
   hs_data_t exp_b;
   int sent;
   int rcvd;
   int cyc;
   logic push;
   logic pop;

   initial begin
      rst = 1'b1;
      in_valid = 1'b0;
      in_data = '0;
      out_ready = 1'b0;

      // 1. reset
      step(); step(); step();
      chk("rst_ov", 32'(out_valid), 0);
      chk("rst_ir", 32'(in_ready), 0);
      chk("rst_cnt", 32'(count), 0);
      chk("rst_od", 32'(out_data), 0);
      rst = 1'b0;
      step();
      chk("rel_ir", 32'(in_ready), 1);

      // 2. single byte with stall
      in_valid = 1'b1;
      in_data = 8'hA5;
      step();
      in_valid = 1'b0;
      chk("one_ov", 32'(out_valid), 1);
      chk("one_od", 32'(out_data), 32'hA5);
      chk("one_cnt", 32'(count), 1);
      for (int i = 0; i < 5; i++) begin
         step();
         chk("stall_ov", 32'(out_valid), 1);
         chk("stall_od", 32'(out_data), 32'hA5);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("pop_cnt", 32'(count), 0);
      chk("pop_ov", 32'(out_valid), 0);

      // 3. fill to FULL, 5th byte refused
      for (int i = 1; i <= 4; i++) begin
         in_valid = 1'b1;
         in_data = 8'(i);
         step();
      end
      chk("full_cnt", 32'(count), 4);
      chk("full_ir", 32'(in_ready), 0);
      in_data = 8'h05;
      step(); step();
      chk("hold_cnt", 32'(count), 4);
      chk("hold_od", 32'(out_data), 32'h01);
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         chk("drain_od", 32'(out_data), 32'(i));
         step();
      end
      out_ready = 1'b0;
      chk("drain_cnt", 32'(count), 0);

      // 4. streaming with pointer wrap
      out_ready = 1'b1;
      in_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         in_data = 8'(i);
         step();
         chk("strm_od", 32'(out_data), 32'(i));
         chk("strm_cnt", 32'(count), 1);
      end
      in_valid = 1'b0;
      step();
      chk("strm_end", 32'(count), 0);

      // 5. reset mid-stream
      out_ready = 1'b0;
      in_valid = 1'b1;
      in_data = 8'hAA; step();
      in_data = 8'hBB; step();
      in_data = 8'hCC; step();
      in_valid = 1'b0;
      chk("mid_cnt", 32'(count), 3);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mid_ov", 32'(out_valid), 0);
      chk("mid_cnt0", 32'(count), 0);
      chk("mid_ir", 32'(in_ready), 0);
      step();
      chk("mid_ir1", 32'(in_ready), 1);
      in_valid = 1'b1;
      in_data = 8'h7E;
      step();
      in_valid = 1'b0;
      chk("mid_od", 32'(out_data), 32'h7E);
      chk("mid_cnt1", 32'(count), 1);
      out_ready = 1'b1;
      step();
      chk("mid_pop", 32'(count), 0);

      // 6. random backpressure, scoreboard
      sent = 0;
      rcvd = 0;
      cyc = 0;
      while (rcvd < 200 && cyc < 5000) begin
         in_valid = (sent < 200);
         in_data = 8'((sent * 7 + 3) & 8'hFF);
         out_ready = 1'($urandom_range(0, 1));
         #1;
         push = in_valid & in_ready;
         pop = out_valid & out_ready;
         if (pop) begin
            exp_b = q.pop_front();
            chk("rnd_od", 32'(out_data), 32'(exp_b));
            rcvd++;
         end
         if (push) begin
            q.push_back(in_data);
            sent++;
         end
         step();
         cyc++;
      end
      in_valid = 1'b0;
      out_ready = 1'b0;
      chk("rnd_rcvd", 32'(rcvd), 200);
      chk("rnd_cnt", 32'(count), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
